// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-level arbiter sharing one UART_tx between two byte-stream clients

module uart_tx_arbiter #(
    parameter int WDOG_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       valid0,
    input  logic       valid1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       last0,
    input  logic       last1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       ack0,
    output logic       ack1,
    output logic       pkt_done,
    output logic       abort,
    output logic       busy,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done
);

    typedef enum logic [1:0] {IDLE, GRANT, SEND, WAIT} state_t;

    state_t     state;
    state_t     state_next;
    logic       gnt0_next;
    logic       gnt1_next;
    logic       prio;
    logic       prio_next;
    logic       last_flag;
    logic       capture;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       stall_hit;

    assign sel_valid = gnt1 ? valid1 : valid0;
    assign sel_data  = gnt1 ? data1  : data0;
    assign sel_last  = gnt1 ? last1  : last0;

    assign busy = (state != IDLE);
    assign trmt = (state == SEND);

`ifdef TX_ARB_WDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

    logic [15:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == GRANT && state_next == GRANT) begin
            stall_cnt <= stall_cnt + 16'd1;
        end else begin
            stall_cnt <= '0;
        end
    end

    assign stall_hit = (state == GRANT) && !sel_valid && (stall_cnt == WDOG_LAST);
`else
    assign stall_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            prio      <= 1'b0;
            tx_data   <= 8'h00;
            last_flag <= 1'b0;
        end else begin
            state <= state_next;
            gnt0  <= gnt0_next;
            gnt1  <= gnt1_next;
            prio  <= prio_next;
            if (capture) begin
                tx_data   <= sel_data;
                last_flag <= sel_last;
            end
        end
    end

    always_comb begin
        state_next = state;
        gnt0_next  = gnt0;
        gnt1_next  = gnt1;
        prio_next  = prio;
        capture    = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        pkt_done   = 1'b0;
        abort      = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    if (req0 && (!req1 || !prio)) begin
                        gnt0_next = 1'b1;
                    end else begin
                        gnt1_next = 1'b1;
                    end
                    state_next = GRANT;
                end
            end

            GRANT: begin
                if (sel_valid) begin
                    ack0       = gnt0;
                    ack1       = gnt1;
                    capture    = 1'b1;
                    state_next = SEND;
                end else if (stall_hit) begin
                    abort      = 1'b1;
                    gnt0_next  = 1'b0;
                    gnt1_next  = 1'b0;
                    prio_next  = gnt0;
                    state_next = IDLE;
                end
            end

            SEND: begin
                state_next = WAIT;
            end

            WAIT: begin
                if (tx_done) begin
                    if (last_flag) begin
                        pkt_done   = 1'b1;
                        gnt0_next  = 1'b0;
                        gnt1_next  = 1'b0;
                        prio_next  = gnt0;
                        state_next = IDLE;
                    end else begin
                        state_next = GRANT;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, valid0, valid1, last0, last1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, ack0, ack1, pkt_done, abort, busy, trmt;
    logic [7:0] tx_data;
    logic       tx_done;

    int checks = 0;
    int passes = 0;

    uart_tx_arbiter #(.WDOG_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .valid0(valid0), .valid1(valid1),
        .data0(data0), .data1(data1), .last0(last0), .last1(last1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .pkt_done(pkt_done), .abort(abort), .busy(busy), .trmt(trmt),
        .tx_data(tx_data), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int uart_len = 4;
    int uart_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_done  <= 1'b1;
            uart_cnt <= 0;
        end else if (trmt) begin
            tx_done  <= 1'b0;
            uart_cnt <= uart_len;
        end else if (!tx_done) begin
            if (uart_cnt <= 1) tx_done <= 1'b1;
            else uart_cnt <= uart_cnt - 1;
        end
    end

    int trmt_n, ack0_n, ack1_n, pkt_n, abort_n, both_n, gap_n, chg_n, bad_ack_n;
    logic [7:0] trmt_log [16];
    logic [7:0] last_txd;
    logic [7:0] pkt [8];

    always @(posedge clk) begin
        if (rst_n) begin
            if (trmt) begin
                if (trmt_n < 16) trmt_log[trmt_n] = tx_data;
                trmt_n++;
            end
            if (ack0) ack0_n++;
            if (ack1) ack1_n++;
            if ((ack0 && !gnt0) || (ack1 && !gnt1)) bad_ack_n++;
            if (pkt_done) pkt_n++;
            if (abort) abort_n++;
            if (gnt0 && gnt1) both_n++;
            if (busy && !gnt0 && !gnt1) gap_n++;
            if (!tx_done && tx_data !== last_txd) chg_n++;
            last_txd = tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        trmt_n = 0; ack0_n = 0; ack1_n = 0; pkt_n = 0; abort_n = 0;
        both_n = 0; gap_n = 0; chg_n = 0; bad_ack_n = 0;
    endtask

    task automatic wait_gnt(input int c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ((c == 0 && gnt0) || (c == 1 && gnt1)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_pkt(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (pkt_n >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic send_bytes(input int c, input int n, input int drop_idx, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            int w;
            if (c == 0) begin
                valid0 = 1'b1; data0 = pkt[i]; last0 = (i == n - 1);
                if (i == drop_idx) req0 = 1'b0;
            end else begin
                valid1 = 1'b1; data1 = pkt[i]; last1 = (i == n - 1);
                if (i == drop_idx) req1 = 1'b0;
            end
            w = 0;
            #1;
            while (!((c == 0) ? ack0 : ack1)) begin
                if (w >= 600) begin
                    ok = 1'b0;
                    break;
                end
                @(posedge clk);
                #2;
                w++;
            end
            @(posedge clk);
            #1;
            if (c == 0) valid0 = 1'b0;
            else valid1 = 1'b0;
            if (!ok) return;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; valid0 = 1; valid1 = 1; last0 = 0; last1 = 0;
        data0 = 8'h5A; data1 = 8'hA5;
        tick();
        checks++;
        if ({gnt0, gnt1, ack0, ack1, pkt_done, abort, busy, trmt, tx_data} !== 16'h0000)
            $display("FAIL reset_outputs: got %h expected 0000",
                     {gnt0, gnt1, ack0, ack1, pkt_done, abort, busy, trmt, tx_data});
        else passes++;
        valid0 = 0; valid1 = 0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b000) $display("FAIL idle_after_reset: got %b expected 000", {gnt0, gnt1, busy});
        else passes++;
    endtask

    task automatic test_single_packet();
        bit ok;
        clear_counts();
        req0 = 1'b1;
        #1;
        checks++;
        if (gnt0 !== 1'b0) $display("FAIL gnt0_before_edge: got %b expected 0", gnt0);
        else passes++;
        tick();
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b101) $display("FAIL req_to_gnt0: got %b expected 101", {gnt0, gnt1, busy});
        else passes++;
        req0 = 1'b0;
        pkt[0] = 8'hAA; pkt[1] = 8'h55; pkt[2] = 8'h0C;
        send_bytes(0, 3, -1, ok);
        checks++;
        if (!ok) $display("FAIL single_ack_timeout: got no ack expected ack0");
        else passes++;
        wait_pkt(1, ok);
        checks++;
        if (!ok) $display("FAIL single_pkt_done_timeout: got pkt_n=%0d expected 1", pkt_n);
        else passes++;
        checks++;
        if ({trmt_log[0], trmt_log[1], trmt_log[2]} !== 24'hAA550C)
            $display("FAIL single_tx_bytes: got %h expected aa550c", {trmt_log[0], trmt_log[1], trmt_log[2]});
        else passes++;
        checks++;
        if (trmt_n != 3 || ack0_n != 3 || ack1_n != 0)
            $display("FAIL single_counts: got trmt=%0d ack0=%0d ack1=%0d expected 3 3 0", trmt_n, ack0_n, ack1_n);
        else passes++;
        checks++;
        if ({gnt0, busy} !== 2'b00) $display("FAIL single_gnt_cleared: got %b expected 00", {gnt0, busy});
        else passes++;
        tick();
        tick();
        checks++;
        if (pkt_n != 1 || busy !== 1'b0) $display("FAIL single_pkt_pulse: got pkt_n=%0d busy=%b expected 1 0", pkt_n, busy);
        else passes++;
    endtask

    task automatic test_simultaneous();
        bit ok;
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        rst_n = 1'b1;
        clear_counts();
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) $display("FAIL sim_first_winner: got %b expected 10", {gnt0, gnt1});
        else passes++;
        req0 = 1'b0;
        pkt[0] = 8'h11;
        send_bytes(0, 1, -1, ok);
        wait_pkt(1, ok);
        checks++;
        if (!ok) $display("FAIL sim_pkt1_timeout: got pkt_n=%0d expected 1", pkt_n);
        else passes++;
        req0 = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) $display("FAIL sim_second_winner: got %b expected 01", {gnt0, gnt1});
        else passes++;
        pkt[0] = 8'h22;
        send_bytes(1, 1, -1, ok);
        wait_pkt(2, ok);
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) $display("FAIL sim_third_winner: got %b expected 10", {gnt0, gnt1});
        else passes++;
        req0 = 1'b0; req1 = 1'b0;
        pkt[0] = 8'h33;
        send_bytes(0, 1, -1, ok);
        wait_pkt(3, ok);
        checks++;
        if (!ok || {trmt_log[0], trmt_log[1], trmt_log[2]} !== 24'h112233)
            $display("FAIL sim_tx_order: got %h expected 112233", {trmt_log[0], trmt_log[1], trmt_log[2]});
        else passes++;
        checks++;
        if (ack0_n != 2 || ack1_n != 1 || both_n != 0 || bad_ack_n != 0)
            $display("FAIL sim_counts: got ack0=%0d ack1=%0d both=%0d bad=%0d expected 2 1 0 0",
                     ack0_n, ack1_n, both_n, bad_ack_n);
        else passes++;
    endtask

    task automatic test_req_drop();
        bit ok_g, ok_s, ok_p;
        clear_counts();
        req1 = 1'b1;
        wait_gnt(1, ok_g);
        checks++;
        if (!ok_g || gnt0 !== 1'b0) $display("FAIL drop_gnt1: got gnt0=%b gnt1=%b expected 0 1", gnt0, gnt1);
        else passes++;
        pkt[0] = 8'hD1; pkt[1] = 8'hD2; pkt[2] = 8'hD3; pkt[3] = 8'hD4;
        fork
            send_bytes(1, 4, 1, ok_s);
            begin
                data0 = 8'hEE; last0 = 1'b1;
                repeat (50) begin
                    valid0 = ~valid0;
                    tick();
                end
                valid0 = 1'b0;
            end
        join
        wait_pkt(1, ok_p);
        checks++;
        if (!ok_s || !ok_p) $display("FAIL drop_timeout: got send=%b pkt=%b expected 1 1", ok_s, ok_p);
        else passes++;
        checks++;
        if (trmt_n != 4 || {trmt_log[0], trmt_log[1], trmt_log[2], trmt_log[3]} !== 32'hD1D2D3D4)
            $display("FAIL drop_tx_bytes: got n=%0d %h expected 4 d1d2d3d4", trmt_n,
                     {trmt_log[0], trmt_log[1], trmt_log[2], trmt_log[3]});
        else passes++;
        checks++;
        if (ack1_n != 4 || ack0_n != 0) $display("FAIL drop_acks: got ack1=%0d ack0=%0d expected 4 0", ack1_n, ack0_n);
        else passes++;
        checks++;
        if (gap_n != 0 || pkt_n != 1) $display("FAIL drop_gnt_held: got gap=%0d pkt=%0d expected 0 1", gap_n, pkt_n);
        else passes++;
    endtask

    task automatic test_slow_uart();
        bit ok;
        clear_counts();
        uart_len = 50;
        req0 = 1'b1;
        wait_gnt(0, ok);
        req0 = 1'b0;
        pkt[0] = 8'h3C; pkt[1] = 8'hC3;
        send_bytes(0, 2, -1, ok);
        wait_pkt(1, ok);
        checks++;
        if (!ok) $display("FAIL slow_timeout: got pkt_n=%0d expected 1", pkt_n);
        else passes++;
        checks++;
        if (trmt_n != 2 || {trmt_log[0], trmt_log[1]} !== 16'h3CC3)
            $display("FAIL slow_trmt: got n=%0d %h expected 2 3cc3", trmt_n, {trmt_log[0], trmt_log[1]});
        else passes++;
        checks++;
        if (chg_n != 0) $display("FAIL slow_txdata_stable: got %0d changes expected 0", chg_n);
        else passes++;
        uart_len = 4;
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_counts();
        uart_len = 20;
        req1 = 1'b1;
        wait_gnt(1, ok);
        valid1 = 1'b1; data1 = 8'h77; last1 = 1'b0;
        #1;
        checks++;
        if (ack1 !== 1'b1) $display("FAIL rmid_ack1: got %b expected 1", ack1);
        else passes++;
        tick();
        valid1 = 1'b0;
        checks++;
        if (trmt !== 1'b1 || tx_data !== 8'h77) $display("FAIL rmid_trmt: got %b %h expected 1 77", trmt, tx_data);
        else passes++;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        valid1 = 1'b1;
        #1;
        checks++;
        if ({gnt0, gnt1, ack0, ack1, pkt_done, abort, busy, trmt, tx_data} !== 16'h0000)
            $display("FAIL rmid_outputs: got %h expected 0000",
                     {gnt0, gnt1, ack0, ack1, pkt_done, abort, busy, trmt, tx_data});
        else passes++;
        valid1 = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (gnt1 !== 1'b0) $display("FAIL rmid_gnt_early: got %b expected 0", gnt1);
        else passes++;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) $display("FAIL rmid_regrant: got %b expected 01", {gnt0, gnt1});
        else passes++;
        req1 = 1'b0;
        uart_len = 4;
        pkt[0] = 8'h78;
        send_bytes(1, 1, -1, ok);
        wait_pkt(1, ok);
        checks++;
        if (!ok || trmt_log[1] !== 8'h78) $display("FAIL rmid_finish: got %h expected 78", trmt_log[1]);
        else passes++;
    endtask

`ifdef TX_ARB_WDOG_EN
    task automatic test_watchdog();
        bit ok;
        int first_abort;
        logic g0_17, g1_18;
        clear_counts();
        first_abort = 0;
        g0_17 = 1'b1;
        g1_18 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(0, ok);
        for (int k = 1; k <= 20; k++) begin
            if (abort && first_abort == 0) first_abort = k;
            if (k == 17) g0_17 = gnt0;
            if (k == 18) g1_18 = gnt1;
            tick();
        end
        checks++;
        if (first_abort != 16) $display("FAIL wdog_abort_cycle: got %0d expected 16", first_abort);
        else passes++;
        checks++;
        if (g0_17 !== 1'b0 || g1_18 !== 1'b1) $display("FAIL wdog_regrant: got gnt0=%b gnt1=%b expected 0 1", g0_17, g1_18);
        else passes++;
        checks++;
        if (trmt_n != 0 || abort_n != 1) $display("FAIL wdog_counts: got trmt=%0d abort=%0d expected 0 1", trmt_n, abort_n);
        else passes++;
        req0 = 1'b0; req1 = 1'b0;
        pkt[0] = 8'h99;
        send_bytes(1, 1, -1, ok);
        wait_pkt(1, ok);
        checks++;
        if (!ok || trmt_log[0] !== 8'h99) $display("FAIL wdog_finish: got %h expected 99", trmt_log[0]);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_simultaneous();
        test_req_drop();
        test_slow_uart();
        test_reset_mid();
`ifdef TX_ARB_WDOG_EN
        test_watchdog();
`endif
        checks++;
        if (both_n != 0 || bad_ack_n != 0) $display("FAIL global_onehot: got both=%0d bad_ack=%0d expected 0 0", both_n, bad_ack_n);
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level arbiter that shares the single UART_tx transmitter between two byte-stream requesters: client 0 is the telemetry frame source and client 1 is the debug/console message source. It grants the UART to one client for a whole packet, moves bytes one at a time under a valid/ack handshake, and sequences UART_tx through its trmt/tx_done protocol. It sits between the packet sources and UART_tx; the only TX pin driver remains UART_tx.

## Interface
- WDOG_CYCLES, default 1023: number of stall cycles in GRANT before an abort; used only with TX_ARB_WDOG_EN.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req0, req1  in  1 each  client requests a packet slot.
- valid0, valid1  in  1 each  client's byte on dataN/lastN is presented.
- data0, data1  in  8 each  byte presented by the client.
- last0, last1  in  1 each  presented byte is the final byte of the packet.
- gnt0, gnt1  out  1 each  one-hot grant, held for the whole packet; reset 0.
- ack0, ack1  out  1 each  1-cycle pulse when the presented byte is consumed; reset 0.
- pkt_done  out  1  1-cycle pulse when the last byte's tx_done is seen; reset 0.
- abort  out  1  1-cycle watchdog abort pulse; reset 0, tied 0 without the macro.
- busy  out  1  high in every state except IDLE; reset 0.
- trmt  out  1  UART_tx start strobe; reset 0.
- tx_data  out  8  byte to UART_tx (registered tx_byte); reset 0x00.
- tx_done  in  1  UART_tx completion flag. It is high when the UART is idle and complete, and low from the cycle after trmt until the frame ends.

## Operation
- The FSM states are IDLE, GRANT, SEND and WAIT. The reset state is IDLE.
- **IDLE**
  - If either request is high, choose the winner and register its gnt, then go to GRANT.
  - If both requests are high, the client holding priority wins.
  - The priority pointer resets to client 0.
- **GRANT**
  - When valid of the granted client is high: ack that client in the same cycle, capture its data into tx_byte and its last into last_flag, then go to SEND.
  - The valid, data and last inputs of the non-granted client are ignored.
- **SEND**
  - trmt=1 for exactly one cycle, with tx_data=tx_byte. Go to WAIT.
- **WAIT**
  - Hold until tx_done=1.
  - If last_flag=1: clear gnt, pulse pkt_done, give priority to the other client, and go to IDLE.
  - If last_flag=0: go to GRANT.
- A packet ends only on a byte sent with last=1. Deasserting req mid-packet has no effect.
- A single-byte packet is a byte with last=1 in the first GRANT.
- Client contract: data and last must stay stable while valid is high and ack has not been received.
- tx_data changes only at capture in GRANT. It is stable for the whole UART frame.

## Timing
- req to gnt: 1 cycle, i.e. gnt is high on the cycle after req is sampled in IDLE.
- valid in GRANT to ack: same cycle (combinational). valid to trmt: 1 cycle.
- tx_done seen in WAIT with last_flag=0 leads to GRANT next cycle. The next byte's trmt comes at the earliest 2 cycles after tx_done.
- After pkt_done, IDLE lasts 1 cycle. The other client's gnt is high at the earliest 2 cycles after pkt_done.
- gnt0 and gnt1 are never both high. ack is only ever pulsed to the granted client.
- Reset asserted mid-packet clears all outputs immediately and returns the FSM to IDLE with priority on client 0. The UART must be reset by the same rst_n.

## Configuration
- Macro: TX_ARB_WDOG_EN.
- **Defined:** a 10-bit-or-wider stall counter counts cycles spent in GRANT with the granted valid low.
  - It clears on ack and on leaving GRANT.
  - When the count reaches WDOG_CYCLES: pulse abort, clear gnt, move priority to the other client, and go to IDLE. No trmt is issued.
- **Undefined:** no counter exists and abort is tied 0. GRANT waits indefinitely.

## Test plan
- **Single packet:** req0 with 3 bytes 0xAA, 0x55, 0x0C (last on 0x0C). Expected: gnt0 one cycle after req, three trmt pulses with tx_data 0xAA/0x55/0x0C in order, three ack0 pulses, one pkt_done after the third tx_done, and gnt0 low afterwards.
- **Simultaneous requests:** req0 and req1 both rise out of reset. Expected: client 0 is served first, then client 1 on the next packet. Then both request again: client 0 wins again.
- **Request dropped mid-packet:** client 1 deasserts req during its 2nd of 4 bytes. Expected: all 4 bytes are still sent and gnt1 holds until pkt_done. Client 0's valid toggling meanwhile produces no ack0.
- **Slow UART:** hold tx_done low for 50 cycles after each trmt. Expected: exactly one trmt per byte, and tx_data stable during each frame.
- **Reset mid-packet:** drop rst_n during WAIT. Expected: gnt, ack, trmt, pkt_done, busy and tx_data are all 0 immediately. After release, req1 alone is granted one cycle later.
- **Watchdog (TX_ARB_WDOG_EN, WDOG_CYCLES=16):** grant client 0 with valid0 held low. Expected: abort pulse after 16 stall cycles, gnt0 clears, pending req1 is granted 2 cycles later, and no trmt is issued for client 0.
